// File: rtl/zx8x_pkg.sv
// rtl/zx8x_pkg.sv - shared tape player types, pulse counts and default timing
package zx8x_pkg;

  localparam int unsigned CLK_HZ         = 52_000_000;
  localparam int unsigned PHASE_W        = 26;
  localparam int unsigned PULSES_BIT0    = 4;
  localparam int unsigned PULSES_BIT1    = 9;
  localparam int unsigned DEF_PULSE_CYC  = (CLK_HZ / 1_000_000) * 150;
  localparam int unsigned DEF_GAP_CYC    = (CLK_HZ / 1_000_000) * 1300;
  localparam int unsigned DEF_LEADER_CYC = CLK_HZ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_FETCH,
    ST_WAIT,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_GAP
  } tape_state_t;

  // Pulse counter is loaded with the index of the last pulse of the bit.
  function automatic logic [3:0] pulses_last(input logic b);
    return b ? 4'(PULSES_BIT1 - 1) : 4'(PULSES_BIT0 - 1);
  endfunction

endpackage

// File: rtl/zx81_tape_player_if.sv
// rtl/zx81_tape_player_if.sv - control, tape RAM and waveform signals of the player
interface zx81_tape_player_if;

  logic        start;
  logic        stop;
  logic [13:0] tape_len;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        tape_out;

  modport slave (
    input  start, stop, tape_len, rd_data,
    output rd_addr, busy, done, tape_out
  );

  modport master (
    output start, stop, tape_len, rd_data,
    input  rd_addr, busy, done, tape_out
  );

endinterface

// File: rtl/zx81_pulse_gen.sv
// rtl/zx81_pulse_gen.sv - owns the phase counter: leader silence, pulse train and gap of one bit
module zx81_pulse_gen
  import zx8x_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
  parameter int unsigned LEADER_CYC = DEF_LEADER_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lead_i,
  input  logic go_i,
  input  logic bit_i,
  input  logic abort_i,
  output logic tape_o,
  output logic bit_done_o
);

  if (LEADER_CYC > (1 << PHASE_W)) begin : g_width_chk
    $error("LEADER_CYC does not fit the phase counter");
  end

  tape_state_t        state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [3:0]         pcnt_q, pcnt_d;
  logic               tape_q, tape_d;
  logic               last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      tape_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      tape_q  <= tape_d;
    end
  end

  // bit_done_o flags the final cycle so the parent can chain the next bit with no idle cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    tape_d     = tape_q;
    bit_done_o = 1'b0;
    last       = (cnt_q == '0);
    case (state_q)
      ST_LEADER: begin
        if (last) begin
          bit_done_o = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE_HI: begin
        if (last) begin
          state_d = ST_PULSE_LO;
          cnt_d   = PHASE_W'(PULSE_CYC - 1);
          tape_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE_LO: begin
        if (!last) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pcnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = PHASE_W'(GAP_CYC - 1);
        end else begin
          pcnt_d  = pcnt_q - 1'b1;
          state_d = ST_PULSE_HI;
          cnt_d   = PHASE_W'(PULSE_CYC - 1);
          tape_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (last) begin
          bit_done_o = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    if (go_i) begin
      state_d = ST_PULSE_HI;
      cnt_d   = PHASE_W'(PULSE_CYC - 1);
      pcnt_d  = pulses_last(bit_i);
      tape_d  = 1'b1;
    end
    if (lead_i) begin
      state_d = ST_LEADER;
      cnt_d   = PHASE_W'(LEADER_CYC - 1);
      tape_d  = 1'b0;
    end
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tape_d  = 1'b0;
    end
  end

  assign tape_o = tape_q;

endmodule

// File: rtl/zx81_tape_player.sv
// rtl/zx81_tape_player.sv - replays the .p image as a ZX81 cassette waveform
module zx81_tape_player
  import zx8x_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
  parameter int unsigned LEADER_CYC = DEF_LEADER_CYC,
  parameter logic [7:0]  NAME_BYTE  = 8'h80
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  zx81_tape_player_if.slave    tp
);

  tape_state_t state_q, state_d;
  logic [13:0] len_q, len_d;
  logic [13:0] idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [13:0] rd_addr_q, rd_addr_d;
  logic        done_q, done_d;
  logic        lead, go, go_bit, abort, bit_done, tape;

  zx81_pulse_gen #(
    .PULSE_CYC  (PULSE_CYC),
    .GAP_CYC    (GAP_CYC),
    .LEADER_CYC (LEADER_CYC)
  ) u_pulse_gen (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .lead_i     (lead),
    .go_i       (go),
    .bit_i      (go_bit),
    .abort_i    (abort),
    .tape_o     (tape),
    .bit_done_o (bit_done)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      bitn_q    <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      bitn_q    <= bitn_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
    end
  end

  // ST_PULSE_HI stands for "a bit is in flight"; the pulse generator tracks HI/LO/GAP itself.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    bitn_d    = bitn_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    lead      = 1'b0;
    go        = 1'b0;
    go_bit    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tp.start && !tp.stop) begin
          len_d   = tp.tape_len;
          idx_d   = '0;
          state_d = ST_LEADER;
          lead    = 1'b1;
        end
      end
      ST_LEADER: begin
        if (bit_done) begin
          shift_d = NAME_BYTE;
          bitn_d  = 3'd7;
          go      = 1'b1;
          go_bit  = NAME_BYTE[7];
          state_d = ST_PULSE_HI;
        end
      end
      ST_PULSE_HI: begin
        if (bit_done) begin
          if (bitn_q != 3'd0) begin
            shift_d = shift_q << 1;
            bitn_d  = bitn_q - 1'b1;
            go      = 1'b1;
            go_bit  = shift_q[6];
          end else if (idx_q != len_q) begin
            rd_addr_d = idx_q;
            state_d   = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        shift_d = tp.rd_data;
        bitn_d  = 3'd7;
        idx_d   = idx_q + 1'b1;
        go      = 1'b1;
        go_bit  = tp.rd_data[7];
        state_d = ST_PULSE_HI;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tp.stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      lead    = 1'b0;
      go      = 1'b0;
      abort   = 1'b1;
    end
  end

  assign tp.rd_addr  = rd_addr_q;
  assign tp.busy     = (state_q != ST_IDLE);
  assign tp.done     = done_q;
  assign tp.tape_out = tape;

endmodule

// File: tb/tb_zx81_tape_player.sv
// tb/tb_zx81_tape_player.sv - directed bench decoding the waveform against a byte scoreboard
module tb_zx81_tape_player;
  import zx8x_pkg::*;

  localparam int unsigned P = 2;
  localparam int unsigned G = 5;
  localparam int unsigned L = 3;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  zx81_tape_player_if bus ();

  zx81_tape_player #(
    .PULSE_CYC  (P),
    .GAP_CYC    (G),
    .LEADER_CYC (L),
    .NAME_BYTE  (8'h80)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tp      (bus.slave)
  );

  logic [7:0] ram [0:16383];
  always @(posedge clk_sys) bus.rd_data <= ram[bus.rd_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] byte_q [$];

  int busy_cyc = 0, pulse_tot = 0, done_tot = 0;
  int low_run = 0, bit_pulses = 0, nbits = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] exp_byte;
  logic prev = 1'b0;

  // Waveform decoder: a low run longer than a pulse half closes a bit.
  always @(negedge clk_sys) begin
    if (bus.busy) busy_cyc++;
    if (bus.done) done_tot++;
    if (!bus.busy) begin
      bit_pulses = 0;
      nbits      = 0;
      low_run    = 0;
    end else if (bus.tape_out && !prev) begin
      pulse_tot++;
      bit_pulses++;
      low_run = 0;
    end else if (!bus.tape_out) begin
      low_run++;
      if (low_run == P + 1 && bit_pulses > 0) begin
        n_tests++;
        assert (bit_pulses == 4 || bit_pulses == 9) else begin
          n_fail++;
          $error("FAIL bit_pulses: observed %0d expected 4 or 9", bit_pulses);
        end
        sh = {sh[6:0], bit_pulses == 9};
        bit_pulses = 0;
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          n_tests++;
          if (byte_q.size() == 0) begin
            n_fail++;
            $error("FAIL byte_extra: observed %0h expected none", sh);
          end else begin
            exp_byte = byte_q.pop_front();
            assert (sh === exp_byte) else begin
              n_fail++;
              $error("FAIL byte: observed %0h expected %0h", sh, exp_byte);
            end
          end
        end
      end
    end
    prev = bus.tape_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic play(input logic [13:0] len, input int exp_busy, input int exp_pulses,
                      input int restart_at);
    int b0, p0, d0, k;
    byte_q.push_back(8'h80);
    for (int i = 0; i < int'(len); i++) byte_q.push_back(ram[i]);
    b0 = busy_cyc;
    p0 = pulse_tot;
    d0 = done_tot;
    bus.tape_len = len;
    bus.start    = 1'b1;
    @(negedge clk_sys);
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 1);
    chk("leader_silent", 32'(bus.tape_out), 0);
    repeat (2) @(negedge clk_sys);
    chk("leader_end", 32'(bus.tape_out), 0);
    @(negedge clk_sys);
    chk("first_pulse", 32'(bus.tape_out), 1);
    k = 0;
    while (!bus.done && k < 3000) begin
      bus.start = (restart_at > 0 && k == restart_at);
      @(negedge clk_sys);
      k++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 1);
    chk("busy_fall", 32'(bus.busy), 0);
    repeat (2) @(negedge clk_sys);
    chk("done_clear", 32'(bus.done), 0);
    chk("done_once", 32'(done_tot - d0), 1);
    chk("busy_cycles", 32'(busy_cyc - b0), 32'(exp_busy));
    chk("pulse_total", 32'(pulse_tot - p0), 32'(exp_pulses));
    chk("queue_empty", 32'(byte_q.size()), 0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 16384; i++) ram[i] = 8'(i * 37 + 11);
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.tape_len = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_tape", 32'(bus.tape_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_addr", 32'(bus.rd_addr), 0);

    play(14'd0, 191, 37, 0);

    ram[0] = 8'hFF;
    play(14'd1, 521, 109, 200);

    ram[0] = 8'h00;
    ram[1] = 8'h01;
    play(14'd2, 551, 106, 0);

    d0 = done_tot;
    bus.tape_len = 14'd0;
    bus.start    = 1'b1;
    @(negedge clk_sys);
    bus.start = 1'b0;
    repeat (107) @(negedge clk_sys);
    chk("bit3_hi", 32'(bus.tape_out), 1);
    bus.stop = 1'b1;
    @(negedge clk_sys);
    bus.stop = 1'b0;
    chk("stop_tape", 32'(bus.tape_out), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    repeat (4) @(negedge clk_sys);
    chk("stop_no_done", 32'(done_tot - d0), 0);
    play(14'd0, 191, 37, 0);

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk_sys);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("start_stop_busy", 32'(bus.busy), 0);
    @(negedge clk_sys);
    chk("start_stop_busy2", 32'(bus.busy), 0);

    d0 = done_tot;
    bus.start = 1'b1;
    @(negedge clk_sys);
    bus.start = 1'b0;
    repeat (40) @(negedge clk_sys);
    chk("gap_busy", 32'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_tape", 32'(bus.tape_out), 0);
    chk("areset_busy", 32'(bus.busy), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("areset_no_done", 32'(done_tot - d0), 0);
    play(14'd2, 551, 106, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
